// File: rtl/spectral_band_permuter.sv
// -----------------------------------------------------------------------------
// spectral_band_permuter
//
// Buffers one natural-order FFT frame in a ping-pong RAM and streams it out
// with one band of bins (and its Hermitian mirror band) permuted by a key.
// mode=0 applies the key permutation (scramble), mode=1 applies its inverse
// (descramble). Key and mode are latched on the edge that completes a frame.
// An all-zero key bypasses the permutation; a nonzero key with repeated
// fields also bypasses it and flags key_err for the whole output frame.
//
// Ports:
//   clock      master clock
//   reset      synchronous, active-high
//   di_en      input bin valid (gaps allowed)
//   di_re/im   input bin, natural order
//   shift_key  permutation key, field i = shift_key[i*LB +: LB]
//   mode       0 = scramble, 1 = descramble
//   do_en      output bin valid, FRAME_LEN contiguous cycles per frame
//   do_re/im   output bin
//   do_count   index of the bin being output
//   key_err    high with do_en when the frame's latched key was rejected
// -----------------------------------------------------------------------------
module spectral_band_permuter #(
   parameter int  DATA_W     = 16,
   parameter int  FRAME_LEN  = 64,
   parameter int  BAND_LEN   = 8,
   parameter int  BAND_START = 1,
   localparam int LB         = $clog2(BAND_LEN),
   localparam int KEY_W      = BAND_LEN * LB,
   localparam int CW         = $clog2(FRAME_LEN)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              di_en,
   input  logic [DATA_W-1:0] di_re,
   input  logic [DATA_W-1:0] di_im,
   input  logic [KEY_W-1:0]  shift_key,
   input  logic              mode,
   output logic              do_en,
   output logic [DATA_W-1:0] do_re,
   output logic [DATA_W-1:0] do_im,
   output logic [CW-1:0]     do_count,
   output logic              key_err
);

   localparam logic [CW-1:0] LAST_BIN   = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] BAND_LO    = CW'(BAND_START);
   localparam logic [CW-1:0] BAND_HI    = CW'(BAND_START + BAND_LEN - 1);
   localparam logic [CW-1:0] MIRROR_TOP = CW'(FRAME_LEN - BAND_START);
   localparam logic [CW-1:0] MIRROR_LO  = CW'(FRAME_LEN - BAND_START - BAND_LEN + 1);

   typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

   // Write side and active key
   logic [CW-1:0]    wr_cnt;
   logic             wr_bank;
   logic             frame_done;
   logic [KEY_W-1:0] key_q;
   logic             mode_q;
   logic             key_use;   // latched key is valid and nonzero: permute
   logic             key_bad;   // latched key is nonzero with repeated fields

   // Incoming key check
   logic [LB-1:0]    new_field [BAND_LEN];
   logic             new_dup;
   logic             new_zero;

   // Reader
   rd_state_t        rd_state;
   logic [CW-1:0]    rd_cnt;
   logic [LB-1:0]    key_field [BAND_LEN];
   logic [LB-1:0]    inv_field [BAND_LEN];
   logic             in_band;
   logic             in_mirror;
   logic [LB-1:0]    band_off;
   logic [LB-1:0]    perm_off;
   logic [CW-1:0]    src_idx;

   // RAM and read pipeline
   logic [DATA_W-1:0] mem_re [2*FRAME_LEN];
   logic [DATA_W-1:0] mem_im [2*FRAME_LEN];
   logic [DATA_W-1:0] rd_re;
   logic [DATA_W-1:0] rd_im;
   logic              rd_valid;
   logic [CW-1:0]     rd_idx;
   logic              rd_err;

   assign frame_done = di_en && (wr_cnt == LAST_BIN);
   assign new_zero   = (shift_key == '0);

   // NOTE: every signal driven from always_comb gets a default first, so no
   // path through the block leaves it holding a value (which would infer a latch).
   always_comb begin
      new_dup = 1'b0;
      for (int i = 0; i < BAND_LEN; i++) new_field[i] = shift_key[i*LB +: LB];
      for (int i = 0; i < BAND_LEN; i++)
         for (int j = i + 1; j < BAND_LEN; j++)
            if (new_field[i] == new_field[j]) new_dup = 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         key_q   <= '0;
         mode_q  <= 1'b0;
         key_use <= 1'b0;
         key_bad <= 1'b0;
      end else if (di_en) begin
         wr_cnt <= wr_cnt + CW'(1);   // FRAME_LEN is a power of 2: wraps to 0
         if (frame_done) begin
            wr_bank <= ~wr_bank;
            key_q   <= shift_key;
            mode_q  <= mode;
            key_use <= !new_zero && !new_dup;
            key_bad <= !new_zero && new_dup;
         end
      end
   end

   // Reader FSM: one bin per cycle; a completion on the last read cycle
   // restarts immediately so back-to-back frames stream without a gap.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_state <= RD_IDLE;
         rd_cnt   <= '0;
      end else begin
         unique case (rd_state)
            RD_IDLE: begin
               if (frame_done) begin
                  rd_state <= RD_READ;
                  rd_cnt   <= '0;
               end
            end
            RD_READ: begin
               if (rd_cnt == LAST_BIN) begin
                  rd_cnt <= '0;
                  if (!frame_done) rd_state <= RD_IDLE;
               end else begin
                  rd_cnt <= rd_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   // Inverse permutation of the latched key; meaningless (but unused) when the
   // key has repeated fields.
   always_comb begin
      for (int i = 0; i < BAND_LEN; i++) key_field[i] = key_q[i*LB +: LB];
      for (int i = 0; i < BAND_LEN; i++) inv_field[i] = '0;
      for (int i = 0; i < BAND_LEN; i++) inv_field[key_field[i]] = LB'(i);
   end

   // Source bin for the current output bin. The band and its mirror never
   // overlap, so one offset register serves both.
   always_comb begin
      in_band   = (rd_cnt >= BAND_LO) && (rd_cnt <= BAND_HI);
      in_mirror = (rd_cnt >= MIRROR_LO) && (rd_cnt <= MIRROR_TOP);
      band_off  = in_band ? LB'(rd_cnt - BAND_LO) : LB'(MIRROR_TOP - rd_cnt);
      perm_off  = mode_q ? inv_field[band_off] : key_field[band_off];
      src_idx   = rd_cnt;
      if (key_use && in_band)        src_idx = BAND_LO + CW'(perm_off);
      else if (key_use && in_mirror) src_idx = MIRROR_TOP - CW'(perm_off);
   end

   // NOTE: the frame RAM is not reset; the write counter and reader state
   // guarantee stale contents are never presented as valid output.
   always_ff @(posedge clock) begin
      if (di_en) begin
         mem_re[{wr_bank, wr_cnt}] <= di_re;
         mem_im[{wr_bank, wr_cnt}] <= di_im;
      end
      // The reader always drains the bank that is not being written.
      rd_re <= mem_re[{~wr_bank, src_idx}];
      rd_im <= mem_im[{~wr_bank, src_idx}];
   end

   // Read pipeline and output register; key_err travels with its bin so the
   // tail of one frame keeps its own key status across a completion edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_idx   <= '0;
         rd_err   <= 1'b0;
         do_en    <= 1'b0;
         do_re    <= '0;
         do_im    <= '0;
         do_count <= '0;
         key_err  <= 1'b0;
      end else begin
         rd_valid <= (rd_state == RD_READ);
         rd_idx   <= rd_cnt;
         rd_err   <= key_bad;
         do_en    <= rd_valid;
         do_re    <= rd_valid ? rd_re  : '0;
         do_im    <= rd_valid ? rd_im  : '0;
         do_count <= rd_valid ? rd_idx : '0;
         key_err  <= rd_valid && rd_err;
      end
   end

endmodule

// File: tb/tb_spectral_band_permuter.sv
// -----------------------------------------------------------------------------
// tb_spectral_band_permuter
//
// Self-checking bench: frames are driven at negedge, the expected output
// frame is built by a small reference model and queued when the last bin is
// driven, and a negedge monitor pops and compares every do_en cycle.
// -----------------------------------------------------------------------------
module tb_spectral_band_permuter;

   localparam int DATA_W     = 16;
   localparam int FRAME_LEN  = 64;
   localparam int BAND_LEN   = 8;
   localparam int BAND_START = 1;
   localparam int LB         = 3;
   localparam int KEY_W      = 24;
   localparam int CW         = 6;

   localparam logic [KEY_W-1:0] KEY_IDENT = 24'hFAC688;
   localparam logic [KEY_W-1:0] KEY_REV   = 24'h053977;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic [CW-1:0]     cnt;
      logic              err;
   } exp_t;

   logic              clock     = 1'b0;
   logic              reset     = 1'b1;
   logic              di_en     = 1'b0;
   logic [DATA_W-1:0] di_re     = '0;
   logic [DATA_W-1:0] di_im     = '0;
   logic [KEY_W-1:0]  shift_key = '0;
   logic              mode      = 1'b0;
   logic              do_en;
   logic [DATA_W-1:0] do_re;
   logic [DATA_W-1:0] do_im;
   logic [CW-1:0]     do_count;
   logic              key_err;

   spectral_band_permuter #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN),
      .BAND_LEN  (BAND_LEN),
      .BAND_START(BAND_START)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .di_en    (di_en),
      .di_re    (di_re),
      .di_im    (di_im),
      .shift_key(shift_key),
      .mode     (mode),
      .do_en    (do_en),
      .do_re    (do_re),
      .do_im    (do_im),
      .do_count (do_count),
      .key_err  (key_err)
   );

   always #5 clock = ~clock;

   int n_tests  = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int run_len  = 0;
   int rise_cyc = 0;
   int last_cyc = 0;

   exp_t sb_q [$];
   int   runs_q [$];

   logic [DATA_W-1:0] in_re  [FRAME_LEN];
   logic [DATA_W-1:0] in_im  [FRAME_LEN];
   logic [DATA_W-1:0] ref_re [FRAME_LEN];
   logic [DATA_W-1:0] ref_im [FRAME_LEN];
   logic [DATA_W-1:0] exp_re [FRAME_LEN];
   logic [DATA_W-1:0] exp_im [FRAME_LEN];
   logic              exp_err;
   int                kf [BAND_LEN] = '{3, 0, 7, 5, 1, 6, 2, 4};
   logic [KEY_W-1:0]  key_mix;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
      end
   endtask

   // Monitor: compares every valid output bin and records contiguous run lengths.
   always @(negedge clock) begin
      exp_t e;
      if (do_en) begin
         run_len++;
         if (run_len == 1) rise_cyc = cyc;
         if (sb_q.size() == 0) begin
            check("unexpected do_en", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("do_count bin%0d", e.cnt), 32'(do_count), 32'(e.cnt));
            check($sformatf("do_re bin%0d", e.cnt), 32'(do_re), 32'(e.re));
            check($sformatf("do_im bin%0d", e.cnt), 32'(do_im), 32'(e.im));
            check($sformatf("key_err bin%0d", e.cnt), 32'(key_err), 32'(e.err));
         end
      end else begin
         check("key_err idle", 32'(key_err), 32'd0);
         if (run_len != 0) begin
            runs_q.push_back(run_len);
            run_len = 0;
         end
      end
   end

   // Reference model: builds the expected output frame from in_* and the key/mode
   // present when the last bin is driven. Descramble frames expect ref_*.
   task automatic build_expected();
      logic [LB-1:0] f [BAND_LEN];
      bit nz;
      bit ok;
      nz = (shift_key != '0);
      ok = nz;
      for (int i = 0; i < BAND_LEN; i++) f[i] = shift_key[i*LB +: LB];
      for (int i = 0; i < BAND_LEN; i++)
         for (int j = i + 1; j < BAND_LEN; j++)
            if (f[i] == f[j]) ok = 1'b0;
      for (int k = 0; k < FRAME_LEN; k++) begin
         exp_re[k] = in_re[k];
         exp_im[k] = in_im[k];
      end
      if (ok && !mode) begin
         for (int i = 0; i < BAND_LEN; i++) begin
            exp_re[BAND_START+i]           = in_re[BAND_START+int'(f[i])];
            exp_im[BAND_START+i]           = in_im[BAND_START+int'(f[i])];
            exp_re[FRAME_LEN-BAND_START-i] = in_re[FRAME_LEN-BAND_START-int'(f[i])];
            exp_im[FRAME_LEN-BAND_START-i] = in_im[FRAME_LEN-BAND_START-int'(f[i])];
         end
      end else if (ok && mode) begin
         for (int k = 0; k < FRAME_LEN; k++) begin
            exp_re[k] = ref_re[k];
            exp_im[k] = ref_im[k];
         end
      end
      exp_err = nz && !ok;
   endtask

   // Drives one frame from in_*. gap inserts an idle cycle after each bin,
   // chg_at switches shift_key to chg_key before that bin, abort_at applies a
   // reset instead of driving that bin. Returns at a negedge.
   task automatic send_frame(input bit gap, input int chg_at, input logic [KEY_W-1:0] chg_key,
                             input int abort_at);
      exp_t e;
      for (int k = 0; k < FRAME_LEN; k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            di_en = 1'b0;
            @(posedge clock);
            #1;
            sb_q.delete();
            @(negedge clock);
            check("reset do_en", 32'(do_en), 32'd0);
            check("reset do_re", 32'(do_re), 32'd0);
            check("reset do_im", 32'(do_im), 32'd0);
            check("reset do_count", 32'(do_count), 32'd0);
            check("reset key_err", 32'(key_err), 32'd0);
            reset = 1'b0;
            #1;
            runs_q.delete();
            run_len = 0;
            @(negedge clock);
            return;
         end
         if (k == chg_at) shift_key = chg_key;
         di_en = 1'b1;
         di_re = in_re[k];
         di_im = in_im[k];
         if (k == FRAME_LEN - 1) begin
            build_expected();
            for (int b = 0; b < FRAME_LEN; b++) begin
               e.re  = exp_re[b];
               e.im  = exp_im[b];
               e.cnt = CW'(b);
               e.err = exp_err;
               sb_q.push_back(e);
            end
         end
         @(negedge clock);
         if (k == FRAME_LEN - 1) last_cyc = cyc;
         if (gap) begin
            di_en = 1'b0;
            @(negedge clock);
         end
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      di_en = 1'b0;
      while ((sb_q.size() != 0 || do_en) && n < 400) begin
         @(negedge clock);
         n++;
      end
      check("drain within budget", 32'(n < 400), 32'd1);
      repeat (2) @(negedge clock);
   endtask

   task automatic check_runs(input string tag, input int exp_len);
      check($sformatf("%s run count", tag), 32'(runs_q.size()), 32'd1);
      if (runs_q.size() > 0) check($sformatf("%s run length", tag), 32'(runs_q[0]), 32'(exp_len));
      runs_q.delete();
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < FRAME_LEN; k++) begin
         in_re[k] = DATA_W'(k);
         in_im[k] = DATA_W'(16'h100 + k);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("init do_en", 32'(do_en), 32'd0);
      check("init do_re", 32'(do_re), 32'd0);
      check("init do_im", 32'(do_im), 32'd0);
      check("init do_count", 32'(do_count), 32'd0);
      check("init key_err", 32'(key_err), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      runs_q.delete();

      // Identity key: pass-through plus first-output latency
      fill_ramp();
      shift_key = KEY_IDENT;
      mode      = 1'b0;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check("first do_en latency", 32'(rise_cyc - last_cyc), 32'd2);
      check_runs("identity", FRAME_LEN);

      // Reverse key: band and mirror swapped end to end
      shift_key = KEY_REV;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("reverse", FRAME_LEN);

      // Scramble with an arbitrary key, then descramble the scrambled frame
      key_mix = '0;
      for (int i = 0; i < BAND_LEN; i++) key_mix[i*LB +: LB] = LB'(kf[i]);
      for (int k = 0; k < FRAME_LEN; k++) begin
         in_re[k]  = DATA_W'($urandom);
         in_im[k]  = DATA_W'($urandom);
         ref_re[k] = in_re[k];
         ref_im[k] = in_im[k];
      end
      shift_key = key_mix;
      mode      = 1'b0;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("scramble", FRAME_LEN);
      for (int k = 0; k < FRAME_LEN; k++) begin
         in_re[k] = exp_re[k];
         in_im[k] = exp_im[k];
      end
      mode = 1'b1;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("descramble", FRAME_LEN);
      mode = 1'b0;

      // Zero key bypass, then a key with repeated fields
      fill_ramp();
      shift_key = '0;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("zero key", FRAME_LEN);
      shift_key = 24'h000001;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("dup key", FRAME_LEN);

      // Key switched mid-frame 2; frames back to back must stream contiguously
      shift_key = KEY_IDENT;
      send_frame(1'b0, -1, '0, -1);
      send_frame(1'b0, 30, KEY_REV, -1);
      wait_drain();
      check_runs("key switch", 2 * FRAME_LEN);

      // Input valid every other cycle: output still one contiguous frame
      shift_key = KEY_REV;
      send_frame(1'b1, -1, '0, -1);
      wait_drain();
      check_runs("gapped input", FRAME_LEN);

      // Reset during readout of one frame and at bin 20 of the next
      shift_key = KEY_IDENT;
      send_frame(1'b0, -1, '0, -1);
      send_frame(1'b0, -1, '0, 20);
      for (int k = 0; k < FRAME_LEN; k++) begin
         in_re[k] = DATA_W'(16'h8000 + k);
         in_im[k] = DATA_W'(16'h4000 + 3 * k);
      end
      shift_key = KEY_REV;
      send_frame(1'b0, -1, '0, -1);
      wait_drain();
      check_runs("after reset", FRAME_LEN);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
